// File: rtl/loa_pipe_adder_if.sv
// loa_pipe_adder_if: handshake bundle for the pipelined LOA adder.
//   in_valid/in_ready   : input beat handshake (operands, carry-in, approximation level)
//   in_a, in_b          : WIDTH-bit operands
//   in_cin              : carry-in, only meaningful when the approximation level is 0
//   approx_bits         : number of low bits computed with OR instead of add
//   out_valid/out_ready : result handshake
//   out_sum, out_cout   : WIDTH-bit result and carry-out
// The master modport drives beats and consumes results; the adder uses the slave modport.
interface loa_pipe_adder_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned KW    = $clog2(WIDTH + 1)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic [KW-1:0]    approx_bits;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;

    modport master (
        output in_valid, in_a, in_b, in_cin, approx_bits, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, approx_bits, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );
endinterface

// File: rtl/loa_pipe_adder.sv
// loa_pipe_adder: pipelined lower-part-OR approximate adder.
// Adds two WIDTH-bit operands in SEG-bit ripple segments, one segment per stage, giving
// NSEG = WIDTH/SEG cycles of latency and one result per cycle. The low k bits of each beat
// are ORed; the carry into bit k is a[k-1] & b[k-1]; k = 0 gives an exact add with in_cin.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, discards every in-flight beat
//   bus : loa_pipe_adder_if slave modport (valid/ready in, valid/ready out)
module loa_pipe_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG   = 8,
    parameter int unsigned KW    = $clog2(WIDTH + 1)
) (
    input logic             clk,
    input logic             rst,
    loa_pipe_adder_if.slave bus
);
    localparam int unsigned NSEG = WIDTH / SEG;

    if (WIDTH % SEG != 0) begin : g_bad_seg
        $error("loa_pipe_adder: WIDTH must be a multiple of SEG");
    end

    // Per-stage registers. a/b skew registers carry operands of segments not yet added,
    // sum_q accumulates segments already resolved.
    logic [NSEG-1:0]  valid_q;
    logic [NSEG-1:0]  carry_q;
    logic [KW-1:0]    k_q   [NSEG];
    logic [WIDTH-1:0] a_q   [NSEG];
    logic [WIDTH-1:0] b_q   [NSEG];
    logic [WIDTH-1:0] sum_q [NSEG];

    // Stage input chain: index 0 is the input port, index s+1 is the output of stage s.
    logic [NSEG:0]    v_c;
    logic [NSEG:0]    c_c;
    logic [KW-1:0]    k_c   [NSEG+1];
    logic [WIDTH-1:0] a_c   [NSEG+1];
    logic [WIDTH-1:0] b_c   [NSEG+1];
    logic [WIDTH-1:0] s_c   [NSEG+1];

    logic [NSEG-1:0]  carry_d;
    logic [WIDTH-1:0] sum_d [NSEG];

    logic             stall;
    logic [KW-1:0]    k_eff;

    assign k_eff = (bus.approx_bits > KW'(WIDTH)) ? KW'(WIDTH) : bus.approx_bits;

    assign stall        = valid_q[NSEG-1] & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    always_comb begin
        logic c;
        logic ai;
        logic bi;
        v_c[0] = bus.in_valid;
        c_c[0] = bus.in_cin;
        k_c[0] = k_eff;
        a_c[0] = bus.in_a;
        b_c[0] = bus.in_b;
        s_c[0] = '0;
        for (int s = 0; s < NSEG; s++) begin
            v_c[s+1] = valid_q[s];
            c_c[s+1] = carry_q[s];
            k_c[s+1] = k_q[s];
            a_c[s+1] = a_q[s];
            b_c[s+1] = b_q[s];
            s_c[s+1] = sum_q[s];
        end

        for (int s = 0; s < NSEG; s++) begin
            c        = c_c[s];
            sum_d[s] = s_c[s];
            for (int j = 0; j < SEG; j++) begin
                ai = a_c[s][s*SEG + j];
                bi = b_c[s][s*SEG + j];
                if (KW'(s*SEG + j) < k_c[s]) begin
                    // Approximate region; the generate term becomes the carry into bit k.
                    sum_d[s][s*SEG + j] = ai | bi;
                    c                   = ai & bi;
                end else begin
                    sum_d[s][s*SEG + j] = ai ^ bi ^ c;
                    c                   = (ai & bi) | (c & (ai ^ bi));
                end
            end
            carry_d[s] = c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            for (int s = 0; s < NSEG; s++) begin
                k_q[s]   <= '0;
                a_q[s]   <= '0;
                b_q[s]   <= '0;
                sum_q[s] <= '0;
            end
        end else if (!stall) begin
            // Whole pipeline shifts together; bubbles advance like beats.
            for (int s = 0; s < NSEG; s++) begin
                valid_q[s] <= v_c[s];
                carry_q[s] <= carry_d[s];
                k_q[s]     <= k_c[s];
                a_q[s]     <= a_c[s];
                b_q[s]     <= b_c[s];
                sum_q[s]   <= sum_d[s];
            end
        end
    end

    assign bus.out_valid = valid_q[NSEG-1];
    assign bus.out_sum   = sum_q[NSEG-1];
    assign bus.out_cout  = carry_q[NSEG-1];
endmodule

// File: tb/tb_loa_pipe_adder.sv
// tb_loa_pipe_adder: directed and seeded-random checks of loa_pipe_adder.
// Main instance WIDTH=32/SEG=8; two sweep instances WIDTH=16 with SEG=4 and SEG=16.
module tb_loa_pipe_adder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    loa_pipe_adder_if #(.WIDTH(32)) b32 ();
    loa_pipe_adder_if #(.WIDTH(16)) b16a ();
    loa_pipe_adder_if #(.WIDTH(16)) b16b ();

    loa_pipe_adder #(.WIDTH(32), .SEG(8))  dut32  (.clk(clk), .rst(rst), .bus(b32));
    loa_pipe_adder #(.WIDTH(16), .SEG(4))  dut16a (.clk(clk), .rst(rst), .bus(b16a));
    loa_pipe_adder #(.WIDTH(16), .SEG(16)) dut16b (.clk(clk), .rst(rst), .bus(b16b));

    // Golden LOA: returns {cout, sum} in the low w+1 bits.
    function automatic logic [63:0] loa_model(input logic [63:0] a, input logic [63:0] b,
                                              input logic cin, input int unsigned k,
                                              input int unsigned w);
        logic [63:0] mask;
        logic [63:0] r;
        logic [63:0] up;
        logic [63:0] c;
        int unsigned ke;
        mask = (64'd1 << w) - 64'd1;
        a    = a & mask;
        b    = b & mask;
        ke   = (k > w) ? w : k;
        if (ke == 0) begin
            r = a + b + {63'd0, cin};
        end else begin
            c  = (a >> (ke - 1)) & (b >> (ke - 1)) & 64'd1;
            up = (a >> ke) + (b >> ke) + c;
            r  = (up << ke) | ((a | b) & ((64'd1 << ke) - 64'd1));
        end
        return r & ((mask << 1) | 64'd1);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single beat on the 32-bit instance with a measured acceptance-to-output latency.
    task automatic send32(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic [5:0] k,
                          input logic [31:0] exp_sum, input logic exp_cout);
        int lat;
        b32.in_a        = a;
        b32.in_b        = b;
        b32.in_cin      = cin;
        b32.approx_bits = k;
        b32.in_valid    = 1'b1;
        b32.out_ready   = 1'b1;
        #1;
        check({tag, "_in_ready"}, 64'(b32.in_ready), 64'd1);
        tick();
        b32.in_valid = 1'b0;
        lat = 1;
        while (!b32.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_sum"}, 64'(b32.out_sum), 64'(exp_sum));
        check({tag, "_cout"}, 64'(b32.out_cout), 64'(exp_cout));
        tick();
    endtask

    task automatic drive_sw(input logic v, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic [4:0] k);
        b16a.in_valid = v; b16a.in_a = a; b16a.in_b = b; b16a.in_cin = cin;
        b16a.approx_bits = k; b16a.out_ready = 1'b1;
        b16b.in_valid = v; b16b.in_a = a; b16b.in_b = b; b16b.in_cin = cin;
        b16b.approx_bits = k; b16b.out_ready = 1'b1;
    endtask

    initial begin
        logic [31:0] sa [20];
        logic [31:0] sb [20];
        logic        scin [20];
        logic [5:0]  sk [20];
        logic [63:0] exp_q [$];
        logic [63:0] q4 [$];
        logic [63:0] q16 [$];
        logic [63:0] e;
        logic [31:0] hold_sum;
        logic        hold_cout;
        logic        was_stall;
        logic        stall;
        logic        first_seen;
        int          sent;
        int          rcvd;
        int          cyc;
        int          gaps;
        int          seen;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [4:0]  rk;
        logic        rv;

        rst = 1'b1;
        b32.in_valid = 1'b0; b32.in_a = '0; b32.in_b = '0; b32.in_cin = 1'b0;
        b32.approx_bits = '0; b32.out_ready = 1'b0;
        drive_sw(1'b0, 16'h0, 16'h0, 1'b0, 5'd0);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", 64'(b32.out_valid), 64'd0);
        check("rst_out_sum", 64'(b32.out_sum), 64'd0);
        check("rst_out_cout", 64'(b32.out_cout), 64'd0);
        check("rst_in_ready", 64'(b32.in_ready), 64'd1);
        check("rst_sw16_valid", 64'(b16b.out_valid), 64'd0);

        // Directed vectors
        send32("exact_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 6'd0, 32'h0000_0000, 1'b1);
        send32("exact_cin", 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 6'd0, 32'h8000_0000, 1'b0);
        send32("loa_k8", 32'h0000_00FF, 32'h0000_0081, 1'b0, 6'd8, 32'h0000_01FF, 1'b0);
        send32("exact_k0", 32'h0000_00FF, 32'h0000_0081, 1'b0, 6'd0, 32'h0000_0180, 1'b0);
        send32("loa_k8_cin", 32'h0000_00FF, 32'h0000_0081, 1'b1, 6'd8, 32'h0000_01FF, 1'b0);
        send32("clamp_k40", 32'h8000_0000, 32'h8000_0001, 1'b0, 6'd40, 32'h8000_0001, 1'b1);
        send32("loa_k32", 32'hF0F0_0000, 32'h0F0F_0001, 1'b1, 6'd32, 32'hFFFF_0001, 1'b0);

        // Back-to-back stream with a 3-cycle output stall
        for (int i = 0; i < 20; i++) begin
            sa[i]   = $urandom;
            sb[i]   = $urandom;
            scin[i] = 1'($urandom_range(0, 1));
            sk[i]   = 6'($urandom_range(0, 40));
        end
        sent = 0; rcvd = 0; cyc = 0; gaps = 0;
        was_stall = 1'b0; first_seen = 1'b0; hold_sum = '0; hold_cout = 1'b0;
        while (rcvd < 20 && cyc < 100) begin
            b32.out_ready = !(cyc >= 8 && cyc < 11);
            b32.in_valid  = (sent < 20);
            if (sent < 20) begin
                b32.in_a = sa[sent]; b32.in_b = sb[sent];
                b32.in_cin = scin[sent]; b32.approx_bits = sk[sent];
            end
            #1;
            stall = b32.out_valid && !b32.out_ready;
            if (stall) begin
                check("stall_in_ready", 64'(b32.in_ready), 64'd0);
                if (was_stall) begin
                    check("stall_frozen_sum", 64'(b32.out_sum), 64'(hold_sum));
                    check("stall_frozen_cout", 64'(b32.out_cout), 64'(hold_cout));
                end else begin
                    hold_sum  = b32.out_sum;
                    hold_cout = b32.out_cout;
                end
            end else if (b32.out_valid) begin
                check("stream_nonempty", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("stream_result", {31'd0, b32.out_cout, b32.out_sum}, e);
                end
                rcvd++;
            end
            if (first_seen && !b32.out_valid) gaps++;
            if (b32.out_valid) first_seen = 1'b1;
            if (b32.in_valid && b32.in_ready) begin
                exp_q.push_back(loa_model(64'(sa[sent]), 64'(sb[sent]), scin[sent],
                                          int'(sk[sent]), 32));
                sent++;
            end
            was_stall = stall;
            tick();
            cyc++;
        end
        b32.in_valid = 1'b0;
        check("stream_received", 64'(rcvd), 64'd20);
        check("stream_gaps", 64'(gaps), 64'd0);
        check("stream_leftover", 64'(exp_q.size()), 64'd0);

        // Reset mid-stall with three beats in flight
        b32.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b32.in_a = 32'h1111_1111 * (i + 1); b32.in_b = 32'h0101_0101;
            b32.in_cin = 1'b0; b32.approx_bits = 6'd0; b32.in_valid = 1'b1;
            tick();
        end
        b32.in_valid = 1'b0;
        tick();
        check("pre_rst_valid", 64'(b32.out_valid), 64'd1);
        check("pre_rst_sum", 64'(b32.out_sum), 64'h1212_1212);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 64'(b32.out_valid), 64'd0);
        check("mid_rst_sum", 64'(b32.out_sum), 64'd0);
        check("mid_rst_cout", 64'(b32.out_cout), 64'd0);
        check("mid_rst_in_ready", 64'(b32.in_ready), 64'd1);
        b32.out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (b32.out_valid) seen++;
            tick();
        end
        check("rst_discarded", 64'(seen), 64'd0);
        send32("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 6'd0, 32'h2345_6789, 1'b0);

        // Parameter sweep: latency of one directed beat through NSEG=1 and NSEG=4
        drive_sw(1'b1, 16'hFFFF, 16'h0001, 1'b0, 5'd0);
        tick();
        drive_sw(1'b0, 16'h0, 16'h0, 1'b0, 5'd0);
        check("seg16_lat1_valid", 64'(b16b.out_valid), 64'd1);
        check("seg16_sum", 64'(b16b.out_sum), 64'h0000);
        check("seg16_cout", 64'(b16b.out_cout), 64'd1);
        check("seg4_not_yet", 64'(b16a.out_valid), 64'd0);
        tick(); tick(); tick();
        check("seg4_lat4_valid", 64'(b16a.out_valid), 64'd1);
        check("seg4_sum", 64'(b16a.out_sum), 64'h0000);
        check("seg4_cout", 64'(b16a.out_cout), 64'd1);
        tick();

        // Random traffic on both 16-bit instances
        cyc = 0;
        while ((cyc < 40 || q4.size() > 0 || q16.size() > 0) && cyc < 120) begin
            rv = (cyc < 40) && ($urandom_range(0, 3) != 0);
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1)); rk = 5'($urandom_range(0, 20));
            drive_sw(rv, ra, rb, rc, rk);
            #1;
            if (b16a.out_valid) begin
                check("seg4_nonempty", 64'(q4.size() > 0), 64'd1);
                if (q4.size() > 0) begin
                    e = q4.pop_front();
                    check("seg4_result", {47'd0, b16a.out_cout, b16a.out_sum}, e);
                end
            end
            if (b16b.out_valid) begin
                check("seg16_nonempty", 64'(q16.size() > 0), 64'd1);
                if (q16.size() > 0) begin
                    e = q16.pop_front();
                    check("seg16_result", {47'd0, b16b.out_cout, b16b.out_sum}, e);
                end
            end
            e = loa_model(64'(ra), 64'(rb), rc, int'(rk), 16);
            if (rv && b16a.in_ready) q4.push_back(e);
            if (rv && b16b.in_ready) q16.push_back(e);
            tick();
            cyc++;
        end
        check("seg4_drained", 64'(q4.size()), 64'd0);
        check("seg16_drained", 64'(q16.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
